// File: rtl/rect_draw_datapath.sv
// rect_draw_datapath: row-major RECT_W x RECT_H rectangle plotter; define RECT_CLIP_EN to suppress off-screen plots
module rect_draw_datapath #(
  parameter int RECT_W   = 4,
  parameter int RECT_H   = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic [7:0] data_in,
  input  logic [2:0] colour_in,
  input  logic       start_count,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);
`ifdef RECT_CLIP_EN
  localparam logic CLIP = 1'b1;
`else
  localparam logic CLIP = 1'b0;
`endif
  localparam logic [3:0] OX_LAST = 4'(RECT_W - 1);
  localparam logic [3:0] OY_LAST = 4'(RECT_H - 1);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] x_base_q, x_base_d, draw_x_q, draw_x_d, x_out_d;
  logic [6:0] y_base_q, y_base_d, draw_y_q, draw_y_d, y_out_d;
  logic [3:0] ox_q, ox_d, oy_q, oy_d;
  logic [2:0] colour_q, colour_d, colour_out_d;
  logic       plot_d, busy_d, done_d, in_screen;
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  // draw_x/draw_y freeze the bases at start so same-cycle loads only affect the next rectangle
  always_comb begin
    state_d  = state_q;
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    draw_x_d = draw_x_q;
    draw_y_d = draw_y_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: begin
        x_base_d = ld_x ? data_in : x_base_q;
        y_base_d = ld_y ? data_in[6:0] : y_base_q;
        if (start_count) begin
          state_d  = DRAW;
          draw_x_d = x_base_q;
          draw_y_d = y_base_q;
          ox_d     = 4'd0;
          oy_d     = 4'd0;
          colour_d = colour_in;
        end
      end
      DRAW: begin
        ox_d    = (ox_q == OX_LAST) ? 4'd0 : ox_q + 4'd1;
        oy_d    = (ox_q == OX_LAST) ? ((oy_q == OY_LAST) ? 4'd0 : oy_q + 4'd1) : oy_q;
        state_d = (ox_q == OX_LAST && oy_q == OY_LAST) ? DONE : DRAW;
      end
      default: state_d = IDLE;
    endcase
    x_sum        = {1'b0, draw_x_d} + {5'd0, ox_d};
    y_sum        = {1'b0, draw_y_d} + {4'd0, oy_d};
    in_screen    = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);
    x_out_d      = x_sum[7:0];
    y_out_d      = y_sum[6:0];
    colour_out_d = colour_d;
    plot_d       = (state_d == DRAW) && (!CLIP || in_screen);
    busy_d       = state_d != IDLE;
    done_d       = state_d == DONE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      x_base_q   <= '0;
      y_base_q   <= '0;
      draw_x_q   <= '0;
      draw_y_q   <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      colour_q   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_base_q   <= x_base_d;
      y_base_q   <= y_base_d;
      draw_x_q   <= draw_x_d;
      draw_y_q   <= draw_y_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      colour_q   <= colour_d;
      x_out      <= x_out_d;
      y_out      <= y_out_d;
      colour_out <= colour_out_d;
      plot       <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end
endmodule

// File: tb/tb_rect_draw_datapath.sv
// tb_rect_draw_datapath: scoreboard bench for rect_draw_datapath
module tb_rect_draw_datapath;
`ifdef RECT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  typedef logic [17:0] pix_t;
  logic clk = 1'b0, resetn = 1'b0, ld_x = 1'b0, ld_y = 1'b0, start_count = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic plot, busy, done;
  int vectors = 0, miscompares = 0, exp_done = 0, busy_cnt = 0;
  bit abort = 1'b0;
  pix_t pix_q[$];
  pix_t e;
  logic [7:0] mx = '0;
  logic [6:0] my = '0;
  rect_draw_datapath dut (
    .clk(clk), .resetn(resetn), .ld_x(ld_x), .ld_y(ld_y), .data_in(data_in),
    .colour_in(colour_in), .start_count(start_count), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (resetn) begin
    if (plot) begin
      vectors++;
      if (pix_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d need no plot", x_out, y_out, colour_out);
      end else begin
        e = pix_q.pop_front();
        if ({x_out, y_out, colour_out} !== e) begin
          miscompares++;
          $display("FAIL pixel got x=%0d y=%0d c=%0d need x=%0d y=%0d c=%0d",
                   x_out, y_out, colour_out, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    if (done) begin
      vectors++;
      if (exp_done == 0 || pix_q.size() != 0) begin
        miscompares++;
        $display("FAIL done got pending_pixels=%0d pending_done=%0d need 0 and >0", pix_q.size(), exp_done);
      end
      if (exp_done > 0) exp_done--;
    end
    if (busy) busy_cnt++;
    else if (busy_cnt > 0) begin
      if (!abort) begin
        vectors++;
        if (busy_cnt != 17) begin
          miscompares++;
          $display("FAIL busy_len got %0d need 17", busy_cnt);
        end
      end
      busy_cnt = 0;
      abort = 1'b0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int got, input int need);
    vectors++;
    if (got != need) begin
      miscompares++;
      $display("FAIL %s got %0d need %0d", n, got, need);
    end
  endtask
  task automatic load(input bit lx, input bit ly, input logic [7:0] d);
    ld_x = lx; ld_y = ly; data_in = d;
    tick();
    ld_x = 1'b0; ld_y = 1'b0;
    if (lx) mx = d;
    if (ly) my = d[6:0];
  endtask
  task automatic start_draw(input logic [2:0] c, input bit lx, input bit ly, input logic [7:0] d);
    logic [8:0] xs;
    logic [7:0] ys;
    ld_x = lx; ld_y = ly; data_in = d; colour_in = c; start_count = 1'b1;
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++) begin
        xs = 9'(mx) + 9'(ox);
        ys = 8'(my) + 8'(oy);
        if (!CLIP || (xs < 9'd160 && ys < 8'd120)) pix_q.push_back({xs[7:0], ys[6:0], c});
      end
    exp_done++;
    tick();
    ld_x = 1'b0; ld_y = 1'b0; start_count = 1'b0;
    if (lx) mx = d;
    if (ly) my = d[6:0];
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got 0 need 1 within 40 cycles");
    end
    tick();
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_x"}, int'(x_out), 0);
    chk({n, "_y"}, int'(y_out), 0);
    chk({n, "_c"}, int'(colour_out), 0);
    chk({n, "_plot"}, int'(plot), 0);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish need finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    chk_zero("reset");
    resetn = 1'b1;
    tick();
    load(1, 0, 8'd10);
    load(0, 1, 8'd20);
    start_draw(3'b100, 0, 0, 0);
    wait_done();
    start_draw(3'b101, 0, 0, 0);
    repeat (4) tick();
    start_count = 1'b1; ld_x = 1'b1; data_in = 8'd50;
    tick();
    start_count = 1'b0; ld_x = 1'b0;
    wait_done();
    start_draw(3'b110, 0, 0, 0);
    wait_done();
    start_draw(3'b011, 1, 0, 8'd30);
    wait_done();
    start_draw(3'b001, 0, 1, 8'd40);
    wait_done();
    start_draw(3'b111, 0, 0, 0);
    wait_done();
    start_draw(3'b100, 0, 0, 0);
    repeat (7) tick();
    abort = 1'b1;
    resetn = 1'b0;
    #1;
    chk_zero("abort");
    pix_q.delete();
    exp_done--;
    mx = '0; my = '0;
    tick();
    resetn = 1'b1;
    tick();
    chk("idle_after_abort_busy", int'(busy), 0);
    start_draw(3'b010, 0, 0, 0);
    wait_done();
    load(1, 0, 8'd158);
    load(0, 1, 8'd118);
    start_draw(3'b010, 0, 0, 0);
    wait_done();
    load(1, 1, 8'd5);
    start_draw(3'b110, 0, 0, 0);
    wait_done();
    repeat (3) tick();
    chk("pixels_left", pix_q.size(), 0);
    chk("dones_left", exp_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rect_draw_datapath.md
RECT_DRAW_DATAPATH -- requirements
Module: rect_draw_datapath

Interface
REQ-001 Parameter RECT_W, default 4, rectangle width in pixels (1..16).
REQ-002 Parameter RECT_H, default 4, rectangle height in pixels (1..16).
REQ-003 Parameter SCREEN_W, default 160, visible columns; SCREEN_H, default 120, visible rows.
REQ-004 clk  input  1  sole clock; all state changes on posedge.
REQ-005 resetn  input  1  reset; asynchronous and active-low.
REQ-006 ld_x  input  1  load x base from data_in.
REQ-007 ld_y  input  1  load y base from data_in[6:0].
REQ-008 data_in  input  8  coordinate value.
REQ-009 colour_in  input  3  fill colour.
REQ-010 start_count  input  1  one-cycle request to draw the rectangle.
REQ-011 x_out  output  8  pixel column to the VGA adapter.
REQ-012 y_out  output  7  pixel row to the VGA adapter.
REQ-013 colour_out  output  3  pixel colour to the VGA adapter.
REQ-014 plot  output  1  write-enable for the current x_out/y_out/colour_out.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse after the last pixel.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-018 In IDLE, ld_x high at a posedge SHALL load x_base <= data_in; ld_y high SHALL load y_base <= data_in[6:0]; both SHALL be honoured in the same cycle.
REQ-019 ld_x and ld_y SHALL be ignored outside IDLE; the base registers SHALL hold.
REQ-020 start_count SHALL be sampled only in IDLE; start_count high there SHALL move to DRAW next cycle and latch colour_in, offsets ox=0, oy=0.
REQ-021 If ld_x/ld_y and start_count are high in the same IDLE cycle, the newly loaded values SHALL NOT be used; the draw SHALL use the previous bases.
REQ-022 In DRAW, each cycle SHALL present x_out = x_base+ox, y_out = y_base+oy (truncated mod 2^8 / 2^7), colour_out = latched colour, plot = 1.
REQ-023 Scan order SHALL be row-major: ox increments each cycle; at ox=RECT_W-1, ox wraps to 0 and oy increments.
REQ-024 At ox=RECT_W-1, oy=RECT_H-1 the last pixel SHALL be plotted and state SHALL move to DONE.
REQ-025 DRAW SHALL last exactly RECT_W*RECT_H cycles; plot SHALL be low in IDLE and DONE.
REQ-026 In DONE, done SHALL be high for exactly one cycle; the FSM then SHALL return to IDLE.
REQ-027 start_count in DRAW or DONE SHALL be ignored, without queueing.
REQ-028 All outputs SHALL be registered; first plot SHALL occur in the cycle after start_count is sampled.

Reset
REQ-029 resetn low SHALL immediately force state IDLE, x_base=0, y_base=0, ox=oy=0, colour=0, and outputs x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0.
REQ-030 Reset asserted mid-DRAW SHALL abort the rectangle with no further plots; after release the block SHALL wait in IDLE for a new start_count.

Configuration
REQ-031 Macro RECT_CLIP_EN: when defined, plot SHALL be 0 for any pixel whose untruncated sum (9-bit x, 8-bit y) is >= SCREEN_W or >= SCREEN_H; timing and done SHALL be unchanged.
REQ-032 Without RECT_CLIP_EN, every DRAW cycle SHALL plot with truncated coordinates (wrap-around).

Verification
REQ-033 Reset, ld_x data_in=10, ld_y data_in=20, start_count, colour 3'b100 -> 16 consecutive plots (10..13,20..23) row-major, colour 100, done 1 cycle after the last plot, busy high 17 cycles.
REQ-034 start_count pulsed at the 5th DRAW cycle and ld_x data_in=50 mid-draw -> no restart, remaining pixels still at x=10..13; next draw still uses x_base=10.
REQ-035 resetn low during 8th DRAW cycle -> plot=0 and outputs 0 immediately; no done; new start_count after release draws a full 16-pixel rectangle at (0,0).
REQ-036 x_base=158, y_base=118, RECT_CLIP_EN defined -> plot high only for x 158..159 and y 118..119 (4 pixels); 16 DRAW cycles; done as normal.
REQ-037 Same stimulus, RECT_CLIP_EN undefined -> 16 plots; x_out 158,159,160,161; y_out 118..121 (no clipping).
REQ-038 ld_x data_in=30, ld_y data_in=40 and start_count in the same cycle after a previous draw at (10,20) -> draw at (10,20); following draw at (30,40).
